// File: rtl/event_fifo_pkg.sv
// Shared definitions for the shared event FIFO.
// Holds the default geometry, the packet-tally and drop-counter widths, the
// packet typedef and a saturating increment helper used by the diagnostics.
package event_fifo_pkg;

    localparam int unsigned WIDTH       = 64;
    localparam int unsigned FIFO_DEPTH  = 2048;
    localparam int unsigned CNT_WIDTH   = 12;
    localparam int unsigned PTR_WIDTH   = $clog2(FIFO_DEPTH);
    localparam int unsigned TALLY_WIDTH = 16;
    localparam int unsigned DROP_WIDTH  = 8;

    typedef logic [WIDTH-1:0] packet_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_WIDTH-1:0] sat_inc(input logic [DROP_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/shared_event_fifo_if.sv
// Bus between the router/comms side (master) and the shared event FIFO (slave).
//   load_event/channel_event_in/fifo_ack : router write handshake
//   read_fifo_n/data_out                 : comms controller pop strobe and popped packet
//   fifo_empty/full/half/counter         : occupancy status
//   total_packets_lsbs                   : low bits of the accepted-packet tally
//   overflow/underflow/parity/high_water/dropped_count/clear_diagnostics : diagnostics
interface shared_event_fifo_if #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned CNT_WIDTH = 12
);
    logic                 load_event;
    logic [WIDTH-1:0]     channel_event_in;
    logic                 fifo_ack;
    logic                 read_fifo_n;
    logic [WIDTH-1:0]     data_out;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 fifo_half;
    logic [CNT_WIDTH-1:0] fifo_counter;
    logic [3:0]           total_packets_lsbs;
    logic                 fifo_overflow;
    logic                 fifo_underflow;
    logic                 parity_error;
    logic [CNT_WIDTH-1:0] high_water;
    logic                 clear_diagnostics;
    logic [7:0]           dropped_count;

    modport master (
        output load_event, channel_event_in, read_fifo_n, clear_diagnostics,
        input  fifo_ack, data_out, fifo_empty, fifo_full, fifo_half, fifo_counter,
               total_packets_lsbs, fifo_overflow, fifo_underflow, parity_error,
               high_water, dropped_count
    );

    modport slave (
        input  load_event, channel_event_in, read_fifo_n, clear_diagnostics,
        output fifo_ack, data_out, fifo_empty, fifo_full, fifo_half, fifo_counter,
               total_packets_lsbs, fifo_overflow, fifo_underflow, parity_error,
               high_water, dropped_count
    );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port packet store: synchronous write, synchronous read.
// The read register holds its value when re_i is low and resets to zero; the
// array itself is not reset so a foundry macro can replace this module.
//   clk_i, rst_ni      : clock, async active-low reset (read register only)
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i/rdata_o : read port, rdata_o valid after the enabled edge
module fifo_ram #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2048
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/shared_event_fifo.sv
// Shared event FIFO between the channel event router and the comms controller.
// Every offered packet is acked one cycle later; packets offered while full are
// dropped and counted. Pops use an active-low strobe and land in data_out one
// edge later with no wait states. Occupancy flags are registered from the
// next-state count so they always agree with fifo_counter.
//   clk, reset_n : single clock, async active-low reset
//   bus_io       : slave side of shared_event_fifo_if (handshakes, status, diagnostics)
module shared_event_fifo #(
    parameter int unsigned WIDTH      = event_fifo_pkg::WIDTH,
    parameter int unsigned FIFO_DEPTH = event_fifo_pkg::FIFO_DEPTH,
    parameter int unsigned CNT_WIDTH  = event_fifo_pkg::CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    shared_event_fifo_if.slave        bus_io
);

    import event_fifo_pkg::*;

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] DepthCnt = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] HalfCnt  = CNT_WIDTH'(FIFO_DEPTH / 2);

    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [CNT_WIDTH-1:0]   high_water_q, high_water_d;
    logic                   empty_q, empty_d;
    logic                   full_q, full_d;
    logic                   half_q, half_d;
    logic                   ack_q;
    logic [TALLY_WIDTH-1:0] tally_q, tally_d;
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;
    logic                   parity_q, parity_d;
    logic [DROP_WIDTH-1:0]  dropped_q, dropped_d;
    logic                   wr_ok, wr_drop, rd_ok, rd_under;
    logic [WIDTH-1:0]       rd_data;

    always_comb begin
        // Both requests judge against the registered (start-of-cycle) flags.
        wr_ok    = bus_io.load_event & ~full_q;
        wr_drop  = bus_io.load_event & full_q;
        rd_ok    = ~bus_io.read_fifo_n & ~empty_q;
        rd_under = ~bus_io.read_fifo_n & empty_q;

        // Depth is a power of two, so natural pointer rollover is the wrap.
        wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;

        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        empty_d = (count_d == '0);
        full_d  = (count_d == DepthCnt);
        half_d  = (count_d >= HalfCnt);

        tally_d = wr_ok ? tally_q + 1'b1 : tally_q;

        overflow_d   = overflow_q | wr_drop;
        underflow_d  = underflow_q | rd_under;
        parity_d     = parity_q | (wr_ok & ~(^bus_io.channel_event_in));
        dropped_d    = wr_drop ? sat_inc(dropped_q) : dropped_q;
        high_water_d = (count_d > high_water_q) ? count_d : high_water_q;

        // Clear wins over any same-cycle set; high-water restarts at occupancy.
        if (bus_io.clear_diagnostics) begin
            overflow_d   = 1'b0;
            underflow_d  = 1'b0;
            parity_d     = 1'b0;
            dropped_d    = '0;
            high_water_d = count_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            high_water_q <= '0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            half_q       <= 1'b0;
            ack_q        <= 1'b0;
            tally_q      <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            parity_q     <= 1'b0;
            dropped_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            high_water_q <= high_water_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
            half_q       <= half_d;
            ack_q        <= bus_io.load_event;
            tally_q      <= tally_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            parity_q     <= parity_d;
            dropped_q    <= dropped_d;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_ram (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .we_i    (wr_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus_io.channel_event_in),
        .re_i    (rd_ok),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    assign bus_io.fifo_ack           = ack_q;
    assign bus_io.data_out           = rd_data;
    assign bus_io.fifo_empty         = empty_q;
    assign bus_io.fifo_full          = full_q;
    assign bus_io.fifo_half          = half_q;
    assign bus_io.fifo_counter       = count_q;
    assign bus_io.total_packets_lsbs = tally_q[3:0];
    assign bus_io.fifo_overflow      = overflow_q;
    assign bus_io.fifo_underflow     = underflow_q;
    assign bus_io.parity_error       = parity_q;
    assign bus_io.high_water         = high_water_q;
    assign bus_io.dropped_count      = dropped_q;

endmodule

// File: tb/tb_shared_event_fifo.sv
// Self-checking bench for shared_event_fifo with a queue-based reference model.
module tb_shared_event_fifo;

    localparam int DEPTH = 2048;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    shared_event_fifo_if #(.WIDTH(64), .CNT_WIDTH(12)) bus ();

    shared_event_fifo #(
        .WIDTH      (64),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (12)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus_io  (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: behaviour of the FIFO stated as queue operations.
    logic [63:0] m_q[$];
    logic [63:0] m_data = '0;
    int          m_tally = 0;
    bit          m_ovf = 0, m_udf = 0, m_par = 0;
    int          m_hw = 0;
    int          m_drop = 0;
    bit          m_was_full, m_was_empty;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_data = '0; m_tally = 0; m_ovf = 0; m_udf = 0; m_par = 0; m_hw = 0; m_drop = 0;
        end else begin
            m_was_full  = (m_q.size() == DEPTH);
            m_was_empty = (m_q.size() == 0);
            if (!bus.read_fifo_n) begin
                if (m_was_empty) m_udf = 1;
                else m_data = m_q.pop_front();
            end
            if (bus.load_event) begin
                if (m_was_full) begin
                    m_ovf = 1;
                    m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                end else begin
                    m_q.push_back(bus.channel_event_in);
                    m_tally = (m_tally + 1) % 65536;
                    if ((^bus.channel_event_in) == 1'b0) m_par = 1;
                end
            end
            if (bus.clear_diagnostics) begin
                m_ovf = 0; m_udf = 0; m_par = 0; m_drop = 0;
                m_hw = m_q.size();
            end else if (m_q.size() > m_hw) begin
                m_hw = m_q.size();
            end
        end
    end

    function automatic logic [63:0] odd_pkt();
        logic [63:0] x;
        x = {$urandom(), $urandom()};
        if ((^x) == 1'b0) x[63] = ~x[63];
        return x;
    endfunction

    // One clock of stimulus; returns #1 after the sampling edge.
    task automatic step(input logic ld, input logic [63:0] pkt, input logic pop,
                        input logic clr);
        bus.load_event        = ld;
        bus.channel_event_in  = pkt;
        bus.read_fifo_n       = ~pop;
        bus.clear_diagnostics = clr;
        @(posedge clk);
        #1;
        bus.load_event        = 1'b0;
        bus.read_fifo_n       = 1'b1;
        bus.clear_diagnostics = 1'b0;
    endtask

    task automatic drain_checked();
        while (m_q.size() > 0) begin
            step(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (bus.data_out !== m_data) begin
                $display("FAIL drain_data: got %h want %h", bus.data_out, m_data);
                failures++;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.fifo_empty, bus.fifo_full, bus.fifo_half, bus.fifo_ack} !== 4'b1000) begin
            $display("FAIL reset_flags: got %b want 1000",
                     {bus.fifo_empty, bus.fifo_full, bus.fifo_half, bus.fifo_ack});
            failures++;
        end
        checks++;
        if ({bus.fifo_counter, bus.high_water, bus.total_packets_lsbs, bus.dropped_count}
            !== 36'd0) begin
            $display("FAIL reset_counts: got cnt=%0d hw=%0d lsbs=%0d drop=%0d want all 0",
                     bus.fifo_counter, bus.high_water, bus.total_packets_lsbs,
                     bus.dropped_count);
            failures++;
        end
        checks++;
        if ({bus.fifo_overflow, bus.fifo_underflow, bus.parity_error} !== 3'b000
            || bus.data_out !== 64'd0) begin
            $display("FAIL reset_diag: got sticky=%b data=%h want 000 and 0",
                     {bus.fifo_overflow, bus.fifo_underflow, bus.parity_error}, bus.data_out);
            failures++;
        end
        reset_n = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_basic();
        logic [63:0] p [3];
        for (int i = 0; i < 3; i++) p[i] = odd_pkt();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, p[i], 1'b0, 1'b0);
            checks++;
            if (bus.fifo_ack !== 1'b1) begin
                $display("FAIL basic_ack%0d: got %b want 1", i, bus.fifo_ack);
                failures++;
            end
        end
        checks++;
        if (bus.fifo_counter !== 12'd3 || bus.total_packets_lsbs !== 4'd3) begin
            $display("FAIL basic_count: got cnt=%0d lsbs=%0d want 3/3",
                     bus.fifo_counter, bus.total_packets_lsbs);
            failures++;
        end
        step(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (bus.fifo_ack !== 1'b0) begin
            $display("FAIL basic_ack_end: got %b want 0", bus.fifo_ack);
            failures++;
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (bus.data_out !== p[i]) begin
                $display("FAIL basic_pop%0d: got %h want %h", i, bus.data_out, p[i]);
                failures++;
            end
        end
        checks++;
        if (bus.fifo_empty !== 1'b1 || bus.fifo_counter !== 12'd0) begin
            $display("FAIL basic_empty: got empty=%b cnt=%0d want 1/0",
                     bus.fifo_empty, bus.fifo_counter);
            failures++;
        end
    endtask

    task automatic test_fill();
        int tally_before;
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, odd_pkt(), 1'b0, 1'b0);
            checks++;
            if (bus.fifo_counter !== 12'(i) || bus.fifo_half !== (i >= DEPTH / 2)
                || bus.fifo_full !== (i == DEPTH) || bus.fifo_empty !== 1'b0) begin
                $display("FAIL fill_%0d: got cnt=%0d half=%b full=%b empty=%b", i,
                         bus.fifo_counter, bus.fifo_half, bus.fifo_full, bus.fifo_empty);
                failures++;
            end
        end
        checks++;
        if (bus.high_water !== 12'd2048) begin
            $display("FAIL fill_hw: got %0d want 2048", bus.high_water);
            failures++;
        end
        tally_before = m_tally;
        step(1'b1, odd_pkt(), 1'b0, 1'b0);
        checks++;
        if (bus.fifo_ack !== 1'b1 || bus.fifo_overflow !== 1'b1 || bus.dropped_count !== 8'd1) begin
            $display("FAIL fill_drop: got ack=%b ovf=%b drop=%0d want 1/1/1",
                     bus.fifo_ack, bus.fifo_overflow, bus.dropped_count);
            failures++;
        end
        checks++;
        if (bus.total_packets_lsbs !== 4'(tally_before) || bus.fifo_counter !== 12'd2048) begin
            $display("FAIL fill_tally: got lsbs=%0d cnt=%0d want %0d/2048",
                     bus.total_packets_lsbs, bus.fifo_counter, tally_before % 16);
            failures++;
        end
    endtask

    task automatic test_simultaneous();
        step(1'b1, odd_pkt(), 1'b1, 1'b0);
        checks++;
        if (bus.fifo_counter !== 12'd2047 || bus.fifo_full !== 1'b0 || bus.dropped_count !== 8'd2
            || bus.data_out !== m_data) begin
            $display("FAIL simul_full: got cnt=%0d full=%b drop=%0d data=%h want 2047/0/2/%h",
                     bus.fifo_counter, bus.fifo_full, bus.dropped_count, bus.data_out, m_data);
            failures++;
        end
        while (m_q.size() > 5) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, odd_pkt(), 1'b1, 1'b0);
        checks++;
        if (bus.fifo_counter !== 12'd5 || bus.data_out !== m_data) begin
            $display("FAIL simul_mid: got cnt=%0d data=%h want 5/%h",
                     bus.fifo_counter, bus.data_out, m_data);
            failures++;
        end
        drain_checked();
    endtask

    task automatic test_underflow_clear();
        logic [63:0] prev;
        prev = m_data;
        step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (bus.fifo_underflow !== 1'b1 || bus.data_out !== prev || bus.fifo_counter !== 12'd0) begin
            $display("FAIL underflow: got udf=%b data=%h cnt=%0d want 1/%h/0",
                     bus.fifo_underflow, bus.data_out, bus.fifo_counter, prev);
            failures++;
        end
        while (m_q.size() < DEPTH) step(1'b1, odd_pkt(), 1'b0, 1'b0);
        step(1'b1, 64'h0000_0000_0000_0003, 1'b0, 1'b1);
        checks++;
        if ({bus.fifo_overflow, bus.fifo_underflow, bus.parity_error} !== 3'b000
            || bus.dropped_count !== 8'd0) begin
            $display("FAIL clear_sticky: got sticky=%b drop=%0d want 000/0",
                     {bus.fifo_overflow, bus.fifo_underflow, bus.parity_error},
                     bus.dropped_count);
            failures++;
        end
        checks++;
        if (bus.high_water !== 12'd2048 || bus.fifo_ack !== 1'b1) begin
            $display("FAIL clear_hw: got hw=%0d ack=%b want 2048/1", bus.high_water, bus.fifo_ack);
            failures++;
        end
        drain_checked();
    endtask

    task automatic test_parity_wrap();
        logic [63:0] pkt;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            pkt = odd_pkt();
            if (i == 9) pkt[0] = ~pkt[0];
            step(1'b1, pkt, 1'b0, 1'b0);
        end
        checks++;
        if (bus.parity_error !== 1'b1 || bus.total_packets_lsbs !== 4'd1
            || bus.fifo_counter !== 12'd17) begin
            $display("FAIL parity_wrap: got par=%b lsbs=%0d cnt=%0d want 1/1/17",
                     bus.parity_error, bus.total_packets_lsbs, bus.fifo_counter);
            failures++;
        end
        for (int i = 0; i < 5000; i++) begin
            pkt = {$urandom(), $urandom()};
            step(($urandom_range(7) != 0), pkt, ($urandom_range(3) != 0),
                 ($urandom_range(63) == 0));
            checks++;
            if (bus.fifo_counter !== 12'(m_q.size()) || bus.data_out !== m_data) begin
                $display("FAIL stream_%0d: got cnt=%0d data=%h want %0d/%h", i,
                         bus.fifo_counter, bus.data_out, m_q.size(), m_data);
                failures++;
            end
            checks++;
            if (bus.high_water !== 12'(m_hw)
                || {bus.fifo_overflow, bus.fifo_underflow, bus.parity_error}
                   !== {m_ovf, m_udf, m_par}
                || bus.total_packets_lsbs !== 4'(m_tally)) begin
                $display("FAIL stream_diag_%0d: got hw=%0d sticky=%b lsbs=%0d want %0d/%b/%0d",
                         i, bus.high_water,
                         {bus.fifo_overflow, bus.fifo_underflow, bus.parity_error},
                         bus.total_packets_lsbs, m_hw, {m_ovf, m_udf, m_par}, m_tally % 16);
                failures++;
            end
        end
        drain_checked();
    endtask

    task automatic test_reset_mid();
        logic [63:0] pkt;
        for (int i = 0; i < 11; i++) step(1'b1, odd_pkt(), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.fifo_counter !== 12'd0 || bus.fifo_empty !== 1'b1 || bus.data_out !== 64'd0) begin
            $display("FAIL reset_mid: got cnt=%0d empty=%b data=%h want 0/1/0",
                     bus.fifo_counter, bus.fifo_empty, bus.data_out);
            failures++;
        end
        #1;
        reset_n = 1'b1;
        pkt = odd_pkt();
        step(1'b1, pkt, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (bus.data_out !== pkt || bus.fifo_empty !== 1'b1) begin
            $display("FAIL reset_mid_reuse: got data=%h empty=%b want %h/1",
                     bus.data_out, bus.fifo_empty, pkt);
            failures++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.load_event        = 1'b0;
        bus.channel_event_in  = '0;
        bus.read_fifo_n       = 1'b1;
        bus.clear_diagnostics = 1'b0;
        test_reset();
        test_basic();
        test_fill();
        test_simultaneous();
        test_underflow_clear();
        test_parity_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
